// File: rtl/vid_sync_gen.sv
// Video timing sequencer: pixel phase counter, h/v counters, display enables, syncs and strobes.
// Optional vertical-blank interrupt enabled by defining VID_SYNC_GEN_VBLANK_IRQ_EN.
module vid_sync_gen #(
  parameter int PIX_DIV = 1,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        run,
  input  logic        irq_ack,
  output logic [3:0]  pc_ena,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        hde,
  output logic        vde,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank_irq
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // 13-bit thresholds so a 4096-long line/frame does not alias to zero
  localparam logic [12:0] H_ACT  = 13'(H_RES);
  localparam logic [12:0] HS_BEG = 13'(H_RES + H_FP);
  localparam logic [12:0] HS_END = 13'(H_RES + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT  = 13'(V_RES);
  localparam logic [12:0] VS_BEG = 13'(V_RES + V_FP);
  localparam logic [12:0] VS_END = 13'(V_RES + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [3:0]  PIX_LAST = 4'(PIX_DIV - 1);
  localparam logic        HS_ON  = 1'(HS_POL);
  localparam logic        VS_ON  = 1'(VS_POL);
  localparam logic        ARM_EN = (PIX_DIV > 1);

  logic        armed;
  logic        step, new_line;
  logic [3:0]  pc_nxt;
  logic [11:0] h_nxt, v_nxt;
  logic [12:0] hx, vx;

  // armed: the first pixel step after hold lands on the origin itself (PIX_DIV > 1 only)
  always_comb begin
    step   = (pc_ena == PIX_LAST);
    pc_nxt = step ? 4'd0 : 4'(pc_ena + 4'd1);
    h_nxt  = h_count;
    v_nxt  = v_count;
    if (step && !(ARM_EN && armed)) begin
      if (h_count == H_LAST) begin
        h_nxt = 12'd0;
        v_nxt = (v_count == V_LAST) ? 12'd0 : 12'(v_count + 12'd1);
      end else begin
        h_nxt = 12'(h_count + 12'd1);
      end
    end
    new_line = step && (h_nxt == 12'd0);
    hx       = {1'b0, h_nxt};
    vx       = {1'b0, v_nxt};
  end

  always_ff @(posedge pclk) begin
    if (reset || !run) begin
      pc_ena      <= 4'd0;
      h_count     <= 12'd0;
      v_count     <= 12'd0;
      hde         <= 1'b1;
      vde         <= 1'b1;
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      armed       <= 1'b1;
    end else begin
      pc_ena      <= pc_nxt;
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      hde         <= (hx < H_ACT);
      vde         <= (vx < V_ACT);
      hs          <= (hx >= HS_BEG && hx < HS_END) ? HS_ON : ~HS_ON;
      vs          <= (vx >= VS_BEG && vx < VS_END) ? VS_ON : ~VS_ON;
      line_start  <= new_line;
      frame_start <= new_line && (v_nxt == 12'd0);
      armed       <= armed && !step;
    end
  end

`ifdef VID_SYNC_GEN_VBLANK_IRQ_EN
  // set beats ack when both land in the same pclk
  always_ff @(posedge pclk) begin
    if (reset || !run)
      vblank_irq <= 1'b0;
    else if (new_line && vx == V_ACT)
      vblank_irq <= 1'b1;
    else if (irq_ack)
      vblank_irq <= 1'b0;
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign vblank_irq     = 1'b0;
`endif

endmodule
